// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - funct_3 encodings of the eight M-extension operations
//   - FSM state type used by muldiv_unit
package muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_op_decoder.sv
// muldiv_op_decoder: combinational decode of the M-extension funct_3 field.
// Ports:
//   funct_3   in  : operation select
//   is_div    out : DIV/DIVU/REM/REMU
//   signed_a  out : rs1 treated as signed (MULH, MULHSU, DIV, REM)
//   signed_b  out : rs2 treated as signed (MULH, DIV, REM)
//   want_high out : return upper half of the product (MULH*)
//   want_rem  out : return remainder instead of quotient (REM*)
module muldiv_op_decoder
    import muldiv_pkg::*;
(
    input  logic [2:0] funct_3,
    output logic       is_div,
    output logic       signed_a,
    output logic       signed_b,
    output logic       want_high,
    output logic       want_rem
);

    always_comb begin
        is_div    = 1'b0;
        signed_a  = 1'b0;
        signed_b  = 1'b0;
        want_high = 1'b0;
        want_rem  = 1'b0;
        case (funct_3)
            MUL:    ;
            MULH:   begin signed_a = 1'b1; signed_b = 1'b1; want_high = 1'b1; end
            MULHSU: begin signed_a = 1'b1; want_high = 1'b1; end
            MULHU:  want_high = 1'b1;
            DIV:    begin is_div = 1'b1; signed_a = 1'b1; signed_b = 1'b1; end
            DIVU:   is_div = 1'b1;
            REM:    begin is_div = 1'b1; signed_a = 1'b1; signed_b = 1'b1; want_rem = 1'b1; end
            REMU:   begin is_div = 1'b1; want_rem = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M execute unit (radix-2 shift-add multiply,
// restoring divide), one operand bit per cycle.
// Ports:
//   clk, rstn            : clock (rising edge), async active-low reset
//   start, flush         : request (taken only when ready), synchronous abort
//   funct_3              : M-extension op select
//   operand_a, operand_b : rs1 / rs2, sampled on the accepting edge
//   ready, busy          : idle and able to accept / op in flight
//   done                 : one-cycle pulse, result valid
//   result               : held until the next completed op
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct_3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    state_t state, state_nxt;
    logic [CNT_W-1:0]   cnt;

    // acc: {hi, lo} product register for multiply; lo doubles as quotient for divide
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   mag_b;
    logic               op_div, op_high, op_rem, neg_main, neg_rem;

    logic dec_is_div, dec_signed_a, dec_signed_b, dec_want_high, dec_want_rem;

    muldiv_op_decoder u_dec (
        .funct_3   (funct_3),
        .is_div    (dec_is_div),
        .signed_a  (dec_signed_a),
        .signed_b  (dec_signed_b),
        .want_high (dec_want_high),
        .want_rem  (dec_want_rem)
    );

    logic             sign_a, sign_b, div_zero, ovf, fast, accept;
    logic [WIDTH-1:0] mag_a_in, mag_b_in, fast_val, fix_val;

    assign sign_a   = dec_signed_a & operand_a[WIDTH-1];
    assign sign_b   = dec_signed_b & operand_b[WIDTH-1];
    // Negating the most-negative value yields the same bit pattern, which is
    // its correct unsigned magnitude.
    assign mag_a_in = cond_neg(operand_a, sign_a);
    assign mag_b_in = cond_neg(operand_b, sign_b);

    assign div_zero = dec_is_div && (operand_b == '0);
    assign ovf      = dec_is_div && dec_signed_a && (operand_a == MOST_NEG) && (operand_b == '1);
    assign fast     = div_zero | ovf;
    assign fast_val = div_zero ? (dec_want_rem ? operand_a : '1)
                               : (dec_want_rem ? '0 : MOST_NEG);

    assign accept = (state == IDLE) && start && !flush;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next;
    logic               div_ok;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_b};
    assign mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    // (WIDTH+1)-bit partial remainder; its top bit is the restore decision
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mag_b};
    assign div_ok    = ~div_trial[WIDTH];

    logic [2*WIDTH-1:0] prod;
    assign prod    = cond_neg_wide(acc, neg_main);
    assign fix_val = op_div ? (op_rem ? cond_neg(rem, neg_rem) : cond_neg(acc[WIDTH-1:0], neg_main))
                            : (op_high ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = fast ? DONE : CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Control: state, iteration counter, visible result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (!flush) begin
                if (accept)
                    cnt <= CNT_W'(WIDTH - 1);
                else if (state == CALC)
                    cnt <= cnt - 1'b1;
                if (state == FIX)
                    result <= fix_val;
                else if (accept && fast)
                    result <= fast_val;
            end
        end
    end

    // Datapath: operand capture and per-bit iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            acc      <= {{WIDTH{1'b0}}, mag_a_in};
            rem      <= '0;
            mag_b    <= mag_b_in;
            op_div   <= dec_is_div;
            op_high  <= dec_want_high;
            op_rem   <= dec_want_rem;
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
        end else if (state == CALC) begin
            if (op_div) begin
                acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
                rem            <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            end else begin
                acc <= mul_next;
            end
        end
    end

    assign ready = (state == IDLE);
    assign busy  = ~ready;
    assign done  = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32).
// Stimulus pushes hand-computed expectations; a forked monitor pops one per
// done pulse and checks result, latency and the ready/done handshake.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   funct_3 = 3'b000;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         ready, busy, done;
    logic [W-1:0] result;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .flush     (flush),
        .funct_3   (funct_3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc_cyc;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        bit   rdy_hi = 1'b0;
        bit   chk_next = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_next) begin
                chk("ready_after_done", ready, 1);
                chk_next = 1'b0;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: done=1 with no op outstanding, result=0x%0h", result);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                    chk({e.name, "_ready_low"}, rdy_hi | ready, 0);
                    rdy_hi   = 1'b0;
                    chk_next = 1'b1;
                end
            end else if (sbq.size() > 0 && ready) begin
                rdy_hi = 1'b1;
            end
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] exp_res, input int lat, input string name);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_wait_ready: ready=0 after 200 cycles, required 1", name);
            return;
        end
        funct_3   = f;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.res     = exp_res;
            e.lat     = lat;
            e.acc_cyc = cyc;
            e.name    = name;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sbq.size() != 0 || !ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;

        // Multiply
        issue(MUL,    32'd7,        32'hFFFFFFFD, 1, 32'hFFFFFFEB, 34, "mul_7xm3");
        issue(MULH,   32'h80000000, 32'h80000000, 1, 32'h40000000, 34, "mulh_neg");
        issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 34, "mulhu_max");
        issue(MULHSU, 32'hFFFFFFFF, 32'd2,        1, 32'hFFFFFFFF, 34, "mulhsu");

        // Divide
        issue(DIV,  32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 34, "div_m7_2");
        issue(REM,  32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 34, "rem_m7_2");
        issue(DIVU, 32'd100,      32'd7, 1, 32'd14,       34, "divu_100_7");
        issue(REMU, 32'd100,      32'd7, 1, 32'd2,        34, "remu_100_7");

        // Fast path: divide by zero and signed overflow
        issue(DIV,  32'd5,        32'd0,        1, 32'hFFFFFFFF, 1, "div_by0");
        issue(REM,  32'd5,        32'd0,        1, 32'd5,        1, "rem_by0");
        issue(REMU, 32'd5,        32'd0,        1, 32'd5,        1, "remu_by0");
        issue(DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1, "div_ovf");
        issue(REM,  32'h80000000, 32'hFFFFFFFF, 1, 32'd0,        1, "rem_ovf");
        wait_idle();

        // start while busy is ignored
        issue(DIVU, 32'd100, 32'd7, 1, 32'd14, 34, "divu_ign");
        repeat (5) @(negedge clk);
        funct_3   = MUL;
        operand_a = 32'd1;
        operand_b = 32'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // flush mid-CALC: no done, result retained
        issue(MUL, 32'd3, 32'd3, 0, '0, 0, "mul_flush");
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", ready, 1);
        chk("flush_result", result, 32'd14);
        repeat (40) @(negedge clk);
        chk("flush_result_held", result, 32'd14);

        // flush together with start in IDLE: start dropped
        funct_3   = MUL;
        operand_a = 32'd9;
        operand_b = 32'd9;
        start     = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_ready", ready, 1);

        issue(MUL, 32'd6, 32'd7, 1, 32'd42, 34, "mul_6x7");
        wait_idle();

        // Async reset mid-CALC
        issue(MUL, 32'd5, 32'd5, 0, '0, 0, "mul_rst");
        repeat (8) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        issue(MULHU, 32'h00010000, 32'h00010000, 1, 32'h00000001, 34, "mulhu_post_rst");
        wait_idle();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M execute unit. It is the successor of the single-cycle ALU control decoder.
- It decodes funct_3 for the eight M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) and runs an iterative radix-2 shift-add multiplier or restoring divider.
- Sits beside the ALU in the execute stage. It uses a start/ready/done handshake so the pipeline can stall on it.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be even and >= 4.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  request. Accepted only when ready=1.
- flush  input  1  synchronous abort of the in-flight op
- funct_3  input  3  M-extension op select (000 MUL … 111 REMU, RISC-V encoding)
- operand_a  input  WIDTH  rs1 value, sampled on the accepting edge
- operand_b  input  WIDTH  rs2 value, sampled on the accepting edge
- ready  output  1  unit idle; able to accept
- busy  output  1  op in flight (equals ~ready)
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  op result. Held stable from done until the next accepting edge.

Behaviour:
- Reset (rstn=0, async): state IDLE, result=0, done=0, busy=0, ready=1. Reset mid-operation discards the op and raises no done.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 samples operands and funct_3.
  - Divide by zero, or signed overflow (DIV/REM with a=most-negative, b=-1): go straight to DONE (fast path).
  - Otherwise: go to CALC, loading the bit counter with WIDTH-1.
- CALC: one bit per cycle. Counter decrements; on counter=0 go to FIX. Lasts exactly WIDTH cycles.
- FIX: conditional two's-complement sign correction; select low half, high half, quotient or remainder. Go to DONE.
- DONE: done=1 for exactly one cycle, result updated on entry; then go to IDLE.
- Latency, counted as rising edges from the accepting edge to the edge that raises done:
  - normal ops: WIDTH+2
  - fast path: 1
- ready=1 only in IDLE. start while not in IDLE is ignored: not queued, no error.
- Signed handling:
  - Signed operands (a for MULH/MULHSU/DIV/REM; b for MULH/DIV/REM) are converted to magnitude before CALC.
  - Product sign = sign_a XOR sign_b, negated over the full 2*WIDTH product.
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
- Multiply: accumulator 2*WIDTH bits. MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide: restoring; partial remainder WIDTH+1 bits.
- Corner results:
  - x/0: DIV/DIVU = all ones; REM/REMU = a.
  - Overflow: DIV = most-negative value; REM = 0.
  - No exceptions are raised.
- flush (synchronous, highest priority after reset): any state goes to IDLE next edge. No done; result keeps its previous value. flush and start in the same IDLE cycle: start is ignored.
- done and ready never assert in the same cycle. ready rises the cycle after done.

Decomposition:
- Package muldiv_pkg: funct_3 localparams (MUL=3'b000 … REMU=3'b111) and state enum typedef (IDLE, CALC, FIX, DONE).
- One combinational sub-module, muldiv_op_decoder. Input funct_3; outputs is_div, signed_a, signed_b, want_high (MULH*), want_rem (REM*).

Test Plan (WIDTH=32):
1. MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 34 edges after accept; ready low throughout, high the cycle after done.
2. MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each with done at 34 edges.
4. DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, REMU 5/0 -> 5; done 1 edge after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; done 1 edge after accept.
5. Start DIVU 100/7, assert start with new operands at CALC cycle 5 -> ignored; result 14. Then flush at CALC cycle 10 of a MUL -> no done, ready next cycle, result still 14. A following MUL 6×7 -> 42.
6. Drop rstn mid-CALC -> result=0, done=0, ready=1 immediately. After release, MULHU 0x10000 × 0x10000 -> 0x00000001.
